// File: rtl/crc8_frame_tx.sv
// Transmit framer in front of the bit-serial CRC-8 engine: SOF, payload, CRC trailer.
// The engine is cleared at every frame start and fed one byte at a time.
module crc8_frame_tx #(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF         = 8'h7E,
    parameter int         CRC_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       crc_rst,
    output logic [7:0] crc_data,
    output logic       crc_valid,
    input  logic [7:0] crc_in,
    input  logic       crc_ready_in,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       frame_trunc
);

    // state | meaning
    // IDLE  | waiting for a payload byte to open a frame
    // CLR   | crc_rst pulse is out, engine being re-initialised
    // SOF   | start-of-frame byte offered downstream
    // LOAD  | accepting the next payload byte
    // SEND  | payload byte offered downstream while the engine digests it
    // TRL   | CRC trailer offered downstream
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SOF,
        ST_LOAD,
        ST_SEND,
        ST_TRL
    } state_t;

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(CRC_TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic          last;
    logic          sent;
    logic          done;
    logic [7:0]    crc_q;
    logic [TW-1:0] timer;
    logic          sent_nx;
    logic          done_nx;
    logic [7:0]    crc_nx;
    logic          at_max;

    assign count_inc = count + CW'(1);
    assign at_max    = (count_inc == CW'(MAX_LEN));
    // crc_ready_in is a single-cycle pulse, so it is folded in the same cycle it arrives
    assign sent_nx   = sent | m_ready;
    assign done_nx   = done | crc_ready_in;
    assign crc_nx    = crc_ready_in ? crc_in : crc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            s_ready     <= 1'b0;
            crc_rst     <= 1'b0;
            crc_data    <= 8'h00;
            crc_valid   <= 1'b0;
            m_data      <= 8'h00;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            frame_err   <= 1'b0;
            frame_trunc <= 1'b0;
            count       <= '0;
            last        <= 1'b0;
            sent        <= 1'b0;
            done        <= 1'b0;
            crc_q       <= 8'h00;
            timer       <= '0;
        end else begin
            crc_rst     <= 1'b0;
            crc_valid   <= 1'b0;
            frame_err   <= 1'b0;
            frame_trunc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        crc_rst <= 1'b1;
                        state   <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    count   <= '0;
                    m_data  <= SOF;
                    m_valid <= 1'b1;
                    m_last  <= 1'b0;
                    state   <= ST_SOF;
                end
                ST_SOF: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        s_ready     <= 1'b0;
                        crc_data    <= s_data;
                        m_data      <= s_data;
                        m_valid     <= 1'b1;
                        crc_valid   <= 1'b1;
                        count       <= count_inc;
                        last        <= s_last | at_max;
                        frame_trunc <= at_max & ~s_last;
                        sent        <= 1'b0;
                        done        <= 1'b0;
                        timer       <= TW'(CRC_TIMEOUT - 1);
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (m_ready) begin
                        sent    <= 1'b1;
                        m_valid <= 1'b0;
                    end
                    if (crc_ready_in) begin
                        done  <= 1'b1;
                        crc_q <= crc_in;
                    end
                    if (sent_nx && done_nx) begin
                        sent <= 1'b0;
                        done <= 1'b0;
                        if (last) begin
                            m_data  <= crc_nx;
                            m_valid <= 1'b1;
                            m_last  <= 1'b1;
                            state   <= ST_TRL;
                        end else begin
                            s_ready <= 1'b1;
                            state   <= ST_LOAD;
                        end
                    end else if (!done_nx) begin
                        // timer was loaded when crc_valid fired; zero here means CRC_TIMEOUT cycles passed
                        if (timer == '0) begin
                            frame_err <= 1'b1;
                            m_valid   <= 1'b0;
                            sent      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                ST_TRL: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Randomised bench for crc8_frame_tx with a behavioural CRC engine and a frame-level
// reference model that predicts the downstream byte stream from the offered payload.
module tb_crc8_frame_tx;

    localparam int         MAX_LEN     = 16;
    localparam logic [7:0] SOF_B       = 8'h7E;
    localparam int         CRC_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       crc_rst;
    logic [7:0] crc_data;
    logic       crc_valid;
    logic [7:0] crc_in;
    logic       crc_ready_in;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       frame_err;
    logic       frame_trunc;

    crc8_frame_tx #(.MAX_LEN(MAX_LEN), .SOF(SOF_B), .CRC_TIMEOUT(CRC_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .crc_rst(crc_rst), .crc_data(crc_data), .crc_valid(crc_valid),
        .crc_in(crc_in), .crc_ready_in(crc_ready_in),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .frame_err(frame_err), .frame_trunc(frame_trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       first;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] up_q[$];
    logic [7:0] trunc_q[$];
    logic [7:0] mcrc = 8'hFF;
    int         plen = 0;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int rst_cnt = 0;
    int sof_seen = 0;
    int trunc_seen = 0;
    int err_cnt = 0;
    int cv_cnt = 0;
    int t_valid = 0;
    int mode = 0;
    logic withhold = 1'b0;
    logic [7:0] last_trailer = 8'h00;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        return r;
    endfunction

    // Reference: frame = SOF, payload (closed by s_last or at MAX_LEN bytes), CRC over payload
    task automatic model_push(input logic [7:0] d, input logic l);
        up_q.push_back({l, d});
        if (plen == 0) exp_q.push_back('{SOF_B, 1'b0, 1'b1});
        exp_q.push_back('{d, 1'b0, 1'b0});
        mcrc = crc8_byte(mcrc, d);
        plen++;
        if (l || plen == MAX_LEN) begin
            if (!l) trunc_q.push_back(d);
            exp_q.push_back('{mcrc, 1'b1, 1'b0});
            plen = 0;
            mcrc = 8'hFF;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((up_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_bound", int'(n < 3000), 1);
        repeat (4) @(posedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (up_q.size() != 0) begin
                s_valid = 1'b1;
                s_data  = up_q[0][7:0];
                s_last  = up_q[0][8];
            end else begin
                s_valid = 1'b0;
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Behavioural engine: clears to 0xFF on crc_rst, answers 10 cycles after crc_valid
    initial begin
        logic [7:0] eacc;
        logic       ebusy;
        int         ecnt;
        eacc = 8'hFF;
        ebusy = 1'b0;
        ecnt = 0;
        crc_ready_in = 1'b0;
        crc_in = 8'h00;
        forever begin
            @(negedge clk);
            crc_ready_in = 1'b0;
            if (!reset) begin
                if (crc_rst) begin
                    eacc = 8'hFF;
                    ebusy = 1'b0;
                end else if (crc_valid) begin
                    chk("crc_valid_while_busy", int'(ebusy), 0);
                    eacc = crc8_byte(eacc, crc_data);
                    ebusy = 1'b1;
                    ecnt = 9;
                end else if (ebusy) begin
                    ecnt--;
                    if (ecnt == 0 && !withhold) begin
                        crc_ready_in = 1'b1;
                        crc_in = eacc;
                        ebusy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (crc_rst) rst_cnt++;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("m_unexpected_byte", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", m_data, e.data);
                        chk("m_last", m_last, e.last);
                        if (e.last) last_trailer = m_data;
                        if (e.first) begin
                            sof_seen++;
                            chk("crc_rst_before_sof", rst_cnt, sof_seen);
                        end
                    end
                end
                if (s_valid && s_ready) void'(up_q.pop_front());
                if (frame_trunc) begin
                    trunc_seen++;
                    if (trunc_q.size() == 0) chk("trunc_unexpected", trunc_q.size(), 1);
                    else chk("trunc_byte", crc_data, trunc_q.pop_front());
                end
                if (frame_err) begin
                    err_cnt++;
                    chk("err_latency", cyc - t_valid, CRC_TIMEOUT);
                end
                if (crc_valid) begin
                    cv_cnt++;
                    t_valid = cyc;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int cv0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({s_ready, crc_rst, crc_valid, m_valid, m_last, frame_err,
                                   frame_trunc, m_data, crc_data}), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // single zero byte
        model_push(8'h00, 1'b1);
        wait_done();
        chk("single_trailer", last_trailer, 8'h35);
        chk("single_crc_rst", rst_cnt, 1);

        // two back-to-back frames: engine must be re-cleared per frame
        model_push(8'h00, 1'b1);
        model_push(8'h00, 1'b1);
        wait_done();
        chk("b2b_trailer", last_trailer, 8'h35);
        chk("b2b_crc_rst", rst_cnt, 3);

        // downstream stalling every other cycle
        mode = 1;
        model_push(8'h01, 1'b0);
        model_push(8'h02, 1'b0);
        model_push(8'h03, 1'b1);
        wait_done();

        // 17 bytes without s_last: truncation at 16, byte 17 opens a new frame
        mode = 0;
        for (int i = 0; i < 17; i++) model_push(8'($urandom), 1'b0);
        model_push(8'($urandom), 1'b1);
        wait_done();
        chk("trunc_count", trunc_seen, 1);

        // engine never answers
        withhold = 1'b1;
        up_q.push_back({1'b1, 8'hA5});
        exp_q.push_back('{SOF_B, 1'b0, 1'b1});
        exp_q.push_back('{8'hA5, 1'b0, 1'b0});
        n = 0;
        while (err_cnt == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("err_bound", int'(n < 200), 1);
        wait_done();
        chk("err_count", err_cnt, 1);
        chk("err_idle_outputs", int'({s_ready, m_valid, m_last}), 0);
        withhold = 1'b0;

        // reset while the second byte of a 4-byte frame is in flight
        cv0 = cv_cnt;
        for (int i = 0; i < 4; i++) model_push(8'($urandom), 1'(i == 3));
        n = 0;
        while (cv_cnt < cv0 + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reset_wait_bound", int'(n < 500), 1);
        #1 reset = 1'b1;
        up_q.delete();
        exp_q.delete();
        trunc_q.delete();
        plen = 0;
        mcrc = 8'hFF;
        #1;
        chk("midframe_reset_outputs", int'({s_ready, crc_rst, crc_valid, m_valid, m_last,
                                            frame_err, frame_trunc, m_data, crc_data}), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) model_push(8'($urandom), 1'(i == 3));
        wait_done();

        // random frames under random backpressure
        mode = 2;
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) model_push(8'($urandom), 1'(i == len - 1));
        end
        wait_done();
        chk("final_trunc_pending", trunc_q.size(), 0);
        chk("final_err_count", err_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/crc8_frame_tx.md
Name: crc8_frame_tx

Overview:
- Transmit framer directly upstream of the bit-serial CRC-8 engine.
- Accepts payload bytes on a valid/ready stream and feeds each byte to the engine (data/data_valid), consuming its crc/crc_ready result.
- Emits a downstream frame: SOF byte, payload bytes, then one CRC byte.
- Re-initialises the engine at the start of every frame, because the engine accumulates across bytes and only reinitialises (to 0xFF) on its reset.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame; the MAX_LEN-th byte is forced as last.
SOF, 8'h7E, start-of-frame byte emitted before the payload.
CRC_TIMEOUT, 16, cycles allowed from crc_valid to crc_ready_in before abort.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
s_data  input  8  payload byte
s_valid  input  1  payload byte valid
s_last  input  1  marks final payload byte of frame
s_ready  output  1  payload byte accepted when s_valid&s_ready
crc_rst  output  1  registered one-cycle clear pulse to the CRC engine reset
crc_data  output  8  byte to CRC engine (data)
crc_valid  output  1  one-cycle pulse to CRC engine (data_valid)
crc_in  input  8  CRC engine result (crc)
crc_ready_in  input  1  CRC engine one-cycle done pulse (crc_ready)
m_data  output  8  frame byte out
m_valid  output  1  frame byte valid
m_last  output  1  high with the CRC byte
m_ready  input  1  downstream accepts when m_valid&m_ready
frame_err  output  1  one-cycle pulse: CRC timeout abort
frame_trunc  output  1  one-cycle pulse: payload truncated at MAX_LEN

Behaviour:
- Reset (async): FSM=IDLE. s_ready, crc_rst, crc_valid, m_valid, m_last, frame_err and frame_trunc are 0; m_data, crc_data and byte count are 0. Reset mid-frame drops the frame with no partial trailer.
- All outputs are registered. s_ready is high only in LOAD. m_data/m_valid/m_last hold stable until accepted.
- IDLE: on s_valid (not consumed) -> CLR.
- CLR: crc_rst=1 for exactly one cycle; count=0 -> SOF.
- SOF: m_data=SOF, m_valid=1; on m_ready -> LOAD.
- LOAD: s_ready=1. On s_valid handshake:
  - latch byte to crc_data and m_data;
  - pulse crc_valid for one cycle;
  - count+1; latch last = s_last | (count+1==MAX_LEN);
  - frame_trunc pulses if count+1==MAX_LEN and s_last=0;
  - -> SEND.
- SEND: m_valid=1 with the payload byte. Two sticky flags:
  - sent: set on m_ready;
  - done: set on crc_ready_in, which also latches crc_in to crc_q. The pulse is single-cycle and must not be missed, even in the same cycle as m_ready.
  - When sent&done: last ? -> TRL : -> LOAD. Flags clear on exit.
- Timeout: a cycle counter starts at crc_valid. If CRC_TIMEOUT cycles elapse without crc_ready_in: pulse frame_err, drop m_valid, -> IDLE.
- TRL: m_data=crc_q, m_valid=1, m_last=1; on m_ready -> IDLE. m_last returns to 0.
- Never pulse crc_valid while a byte is outstanding; the engine ignores data_valid while calculating.
- Engine timing: crc_ready_in arrives 10 cycles after the crc_valid edge. Nominal per-byte throughput is about 11 cycles; downstream stall extends it.
- s_ready=0 in every state but LOAD. Upstream bytes between frames wait; none are dropped.
- CRC byte equals CRC-8 (reflected poly 0x8C, init 0xFF) over the payload only. SOF is excluded.

Test Plan:
- Single byte 0x00 with s_last, m_ready=1 -> m stream 0x7E, 0x00, 0x35 (m_last on 0x35); crc_rst pulsed once before SOF.
- Two back-to-back frames of one byte each (0x00) -> both trailers 0x35, proving crc_rst reinitialises the engine per frame.
- 3-byte frame 0x01,0x02,0x03 with m_ready toggling 1/0 each cycle -> bytes emitted in order, no duplicates; trailer matches model CRC; crc_ready_in coinciding with m_ready stall is captured.
- 17 bytes offered, none with s_last, MAX_LEN=16 -> frame_trunc pulse on byte 16, trailer after byte 16; byte 17 starts a new frame with 0x7E.
- CRC engine model withholds crc_ready_in -> frame_err pulses exactly CRC_TIMEOUT cycles after crc_valid; FSM in IDLE; no m_last.
- Assert reset during SEND of a 4-byte frame -> all outputs 0 immediately; next frame after release is correct with trailer per model.
